mem_port_arbiter: RTL

Arbitrates the single-port unified memory between the core's instruction-fetch port and its load/store data port. Serialises requests and drives the memory command bus. Tracks which requester owns the outstanding access and routes the response back to it. Sits between the Hubris pipeline and the unified memory instance; halt/regstat/memdump benches see memory contents unchanged.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles fetch port, load/store port, memory command bus and busy flag.
// Latency: wires only; timing is set by mem_port_arbiter and MEM_LATENCY.
// Backpressure: each requester holds its req and fields until its gnt.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  // Environment side: the core's two ports plus the memory's read data.
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch and load/store ports onto one single-port memory
//          and routes each response back to its owner. ARB_STATS_EN adds counters.
// Latency: gnt is combinational in a slot; rvalid MEM_LATENCY cycles after gnt.
// Backpressure: one access outstanding; new grants only in IDLE or response cycle.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic              owner_d;
  logic              owner_we;
  logic              resp;
  logic              slot;
  logic              force_if;
  logic              if_win;
  logic              d_win;
  logic              grant;
  logic [ADDR_W-1:0] addr_sel;

  // Response cycle: the outstanding access's data is on mem_rdata now.
  // The reset term keeps grants off while reset is held, even with requests up.
  assign resp     = (state == WAIT) && (lat_cnt == 4'd0);
  assign slot     = reset && ((state == IDLE) || resp);
  assign force_if = (STARVE_LIMIT != 0) && (int'(starve_cnt) >= STARVE_LIMIT);
  assign grant    = if_win || d_win;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Winner selection, next state and memory command; data wins ties unless fetch is starving.
  always_comb begin
    state_nxt     = state;
    if_win        = 1'b0;
    d_win         = 1'b0;
    addr_sel      = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_wdata = 32'h0;
    if (slot) begin
      if (bus.if_req && (!bus.d_req || force_if)) if_win = 1'b1;
      else if (bus.d_req)                          d_win  = 1'b1;
    end
    if (if_win) begin
      addr_sel   = bus.if_addr;
      bus.mem_en = 1'b1;
      bus.mem_be = 4'hF;
    end else if (d_win) begin
      addr_sel      = bus.d_addr;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_wdata = bus.d_wdata;
    end
    bus.mem_addr = addr_sel;
    if (grant)     state_nxt = WAIT;
    else if (resp) state_nxt = IDLE;
  end

  // Owner, access type and latency countdown for the outstanding access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt  <= 4'd0;
      owner_d  <= 1'b0;
      owner_we <= 1'b0;
    end else if (grant) begin
      lat_cnt  <= LAT_INIT;
      owner_d  <= d_win;
      owner_we <= d_win && bus.d_we;
    end else if ((state == WAIT) && (lat_cnt != 4'd0)) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Count slots in which a pending fetch was passed over; saturates at 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         starve_cnt <= 4'd0;
    else if (if_win)                                    starve_cnt <= 4'd0;
    else if (slot && bus.if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
  end

  // Route the response to its owner; rdata stays zero outside a read response.
  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = resp && !owner_d;
  assign bus.d_rvalid  = resp && owner_d;
  assign bus.if_rdata  = (resp && !owner_d) ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = (resp && owner_d && !owner_we) ? bus.mem_rdata : 32'h0;
  assign bus.busy      = (state == WAIT);

`ifdef ARB_STATS_EN
  // Wrapping grant and contention counters, read hierarchically at halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_if_grants <= 32'd0;
      stat_d_grants  <= 32'd0;
      stat_conflicts <= 32'd0;
    end else begin
      if (if_win)                            stat_if_grants <= stat_if_grants + 32'd1;
      if (d_win)                             stat_d_grants  <= stat_d_grants + 32'd1;
      if (slot && bus.if_req && bus.d_req)   stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
